// File: rtl/b_responder.sv
`default_nettype none
// ============================================================================
// Module   : b_responder
// Purpose  : Subordinate-side AXI-style B channel generator. Pairs accepted
//            AW IDs with completed W bursts in order and issues one response
//            per burst.
// Revision : 1.0
// ============================================================================
module b_responder #(
  parameter int ID_WIDTH  = 4,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 aw_valid_i,
  input  logic [ID_WIDTH-1:0]  aw_id_i,
  output logic                 aw_ready_o,
  input  logic                 w_valid_i,
  input  logic                 w_last_i,
  input  logic                 w_err_i,
  output logic                 w_ready_o,
  output logic                 b_valid_o,
  output logic [ID_WIDTH-1:0]  b_id_o,
  output logic [1:0]           b_resp_o,
  input  logic                 b_ready_i,
  output logic [CNT_WIDTH-1:0] outstanding_o
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] C_DEPTH    = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [PTR_WIDTH-1:0] C_PTR_ONE  = PTR_WIDTH'(1);
  localparam logic [1:0]           C_OKAY     = 2'b00;
  localparam logic [1:0]           C_SLVERR   = 2'b10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic [ID_WIDTH-1:0]  r_aw_mem [DEPTH];
  logic [PTR_WIDTH-1:0] r_aw_wptr, r_aw_rptr;
  logic [CNT_WIDTH-1:0] r_aw_cnt;

  logic                 r_wc_mem [DEPTH];
  logic [PTR_WIDTH-1:0] r_wc_wptr, r_wc_rptr;
  logic [CNT_WIDTH-1:0] r_wc_cnt;

  logic                 r_err_acc;
  logic [ID_WIDTH-1:0]  r_b_id;
  logic [1:0]           r_b_resp;
  logic [CNT_WIDTH-1:0] r_outstanding;

  logic w_aw_push, w_beat_acc, w_wc_push, w_b_hs, w_pair_avail, w_pop;

  // Ready comes only from registered counts; a same-cycle pop does not free a slot.
  assign aw_ready_o   = (r_aw_cnt != C_DEPTH);
  assign w_ready_o    = (r_wc_cnt != C_DEPTH);
  assign w_aw_push    = aw_valid_i & aw_ready_o;
  assign w_beat_acc   = w_valid_i & w_ready_o;
  assign w_wc_push    = w_beat_acc & w_last_i;
  assign w_b_hs       = (r_state == RESP) & b_ready_i;
  assign w_pair_avail = (r_aw_cnt != '0) & (r_wc_cnt != '0);

  assign b_valid_o     = (r_state == RESP);
  assign b_id_o        = r_b_id;
  assign b_resp_o      = r_b_resp;
  assign outstanding_o = r_outstanding;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pair_avail) begin
          w_pop       = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (b_ready_i) begin
          if (w_pair_avail) begin
            w_pop = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Storage arrays need no reset: pointers and counts gate every read.
  always_ff @(posedge clk_i) begin
    if (w_aw_push) r_aw_mem[r_aw_wptr] <= aw_id_i;
    if (w_wc_push) r_wc_mem[r_wc_wptr] <= r_err_acc | w_err_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_aw_wptr     <= '0;
      r_aw_rptr     <= '0;
      r_aw_cnt      <= '0;
      r_wc_wptr     <= '0;
      r_wc_rptr     <= '0;
      r_wc_cnt      <= '0;
      r_err_acc     <= 1'b0;
      r_b_id        <= '0;
      r_b_resp      <= C_OKAY;
      r_outstanding <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_aw_push) r_aw_wptr <= r_aw_wptr + C_PTR_ONE;
      if (w_pop)     r_aw_rptr <= r_aw_rptr + C_PTR_ONE;
      case ({w_aw_push, w_pop})
        2'b10:   r_aw_cnt <= r_aw_cnt + C_CNT_ONE;
        2'b01:   r_aw_cnt <= r_aw_cnt - C_CNT_ONE;
        default: r_aw_cnt <= r_aw_cnt;
      endcase

      if (w_wc_push) r_wc_wptr <= r_wc_wptr + C_PTR_ONE;
      if (w_pop)     r_wc_rptr <= r_wc_rptr + C_PTR_ONE;
      case ({w_wc_push, w_pop})
        2'b10:   r_wc_cnt <= r_wc_cnt + C_CNT_ONE;
        2'b01:   r_wc_cnt <= r_wc_cnt - C_CNT_ONE;
        default: r_wc_cnt <= r_wc_cnt;
      endcase

      if (w_beat_acc) begin
        r_err_acc <= w_last_i ? 1'b0 : (r_err_acc | w_err_i);
      end

      if (w_pop) begin
        r_b_id   <= r_aw_mem[r_aw_rptr];
        r_b_resp <= r_wc_mem[r_wc_rptr] ? C_SLVERR : C_OKAY;
      end

      case ({w_aw_push, w_b_hs})
        2'b10:   r_outstanding <= r_outstanding + C_CNT_ONE;
        2'b01:   r_outstanding <= r_outstanding - C_CNT_ONE;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_b_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_b_responder
// Purpose  : Directed self-checking bench for b_responder (DEPTH=4, ID_WIDTH=4).
// Revision : 1.0
// ============================================================================
module tb_b_responder;

  localparam int ID_WIDTH  = 4;
  localparam int DEPTH     = 4;
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1;

  logic                 clk;
  logic                 rst_n;
  logic                 aw_valid;
  logic [ID_WIDTH-1:0]  aw_id;
  logic                 aw_ready;
  logic                 w_valid;
  logic                 w_last;
  logic                 w_err;
  logic                 w_ready;
  logic                 b_valid;
  logic [ID_WIDTH-1:0]  b_id;
  logic [1:0]           b_resp;
  logic                 b_ready;
  logic [CNT_WIDTH-1:0] outstanding;

  int n_vec = 0;
  int n_err = 0;

  b_responder #(
    .ID_WIDTH (ID_WIDTH),
    .DEPTH    (DEPTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .aw_valid_i   (aw_valid),
    .aw_id_i      (aw_id),
    .aw_ready_o   (aw_ready),
    .w_valid_i    (w_valid),
    .w_last_i     (w_last),
    .w_err_i      (w_err),
    .w_ready_o    (w_ready),
    .b_valid_o    (b_valid),
    .b_id_o       (b_id),
    .b_resp_o     (b_resp),
    .b_ready_i    (b_ready),
    .outstanding_o(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the full B-channel view in one call.
  task automatic chk_b(input string tag, input logic v, input logic [3:0] id, input logic [1:0] rsp);
    chk({tag, "_valid"}, 32'(b_valid), 32'(v));
    chk({tag, "_id"},    32'(b_id),    32'(id));
    chk({tag, "_resp"},  32'(b_resp),  32'(rsp));
  endtask

  initial begin
    rst_n = 1'b0; aw_valid = 1'b0; aw_id = '0;
    w_valid = 1'b0; w_last = 1'b0; w_err = 1'b0; b_ready = 1'b0;
    tick(); tick();
    chk("rst_aw_ready", 32'(aw_ready), 32'd1);
    chk("rst_w_ready",  32'(w_ready),  32'd1);
    chk_b("rst", 1'b0, 4'd0, 2'b00);
    chk("rst_outst", 32'(outstanding), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single write: AW then a one-beat burst
    aw_valid = 1'b1; aw_id = 4'd3;
    tick();
    aw_valid = 1'b0;
    chk("t1_outst_1", 32'(outstanding), 32'd1);
    chk("t1_no_b_yet", 32'(b_valid), 32'd0);
    w_valid = 1'b1; w_last = 1'b1; w_err = 1'b0;
    tick();
    w_valid = 1'b0; w_last = 1'b0;
    chk("t1_lat1", 32'(b_valid), 32'd0);
    tick();
    chk_b("t1_resp", 1'b1, 4'd3, 2'b00);
    tick();
    chk_b("t1_hold", 1'b1, 4'd3, 2'b00);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    chk("t1_done_valid", 32'(b_valid), 32'd0);
    chk("t1_outst_0", 32'(outstanding), 32'd0);

    // W before AW: 4-beat burst, error on beat index 1
    for (int i = 0; i < 4; i++) begin
      w_valid = 1'b1; w_last = (i == 3); w_err = (i == 1);
      tick();
    end
    w_valid = 1'b0; w_last = 1'b0; w_err = 1'b0;
    tick();
    chk("t2_no_aw_no_b", 32'(b_valid), 32'd0);
    aw_valid = 1'b1; aw_id = 4'd5;
    tick();
    aw_valid = 1'b0;
    chk("t2_lat1", 32'(b_valid), 32'd0);
    tick();
    chk_b("t2_resp", 1'b1, 4'd5, 2'b10);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    chk("t2_single", 32'(b_valid), 32'd0);
    aw_valid = 1'b1; aw_id = 4'd6; w_valid = 1'b1; w_last = 1'b1;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0; w_last = 1'b0;
    tick();
    chk_b("t2_err_cleared", 1'b1, 4'd6, 2'b00);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    chk("t2_outst_0", 32'(outstanding), 32'd0);

    // Back-to-back responses with b_ready held high
    b_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      aw_valid = 1'b1; aw_id = 4'(i); w_valid = 1'b1; w_last = 1'b1;
      tick();
      if (i >= 2) chk_b("t3_b2b", 1'b1, 4'(i - 1), 2'b00);
      if (i >= 3) chk("t3_outst_simul", 32'(outstanding), 32'd2);
    end
    aw_valid = 1'b0; w_valid = 1'b0; w_last = 1'b0;
    tick();
    chk_b("t3_last", 1'b1, 4'd4, 2'b00);
    tick();
    chk("t3_end_valid", 32'(b_valid), 32'd0);
    chk("t3_outst_0", 32'(outstanding), 32'd0);
    b_ready = 1'b0;

    // Full AW FIFO: 6 offered, only 4 accepted
    aw_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      aw_id = 4'(8 + i);
      chk("t4_aw_ready", 32'(aw_ready), 32'(i < 4));
      tick();
    end
    aw_valid = 1'b0;
    chk("t4_outst_4", 32'(outstanding), 32'd4);
    // Five one-beat bursts, error on the second; the fifth fills the W FIFO
    for (int j = 0; j < 5; j++) begin
      w_valid = 1'b1; w_last = 1'b1; w_err = (j == 1);
      tick();
    end
    w_valid = 1'b0; w_last = 1'b0; w_err = 1'b0;
    chk("t4_w_full", 32'(w_ready), 32'd0);
    chk_b("t4_stable", 1'b1, 4'd8, 2'b00);
    tick();
    chk_b("t4_stable2", 1'b1, 4'd8, 2'b00);
    // Pop on a full W FIFO while a beat is offered: the beat must be refused
    b_ready = 1'b1; w_valid = 1'b1; w_last = 1'b1; w_err = 1'b1;
    chk("t4_w_ready_pushpop", 32'(w_ready), 32'd0);
    tick();
    w_valid = 1'b0; w_last = 1'b0; w_err = 1'b0;
    chk_b("t4_drain9", 1'b1, 4'd9, 2'b10);
    chk("t4_w_ready_after", 32'(w_ready), 32'd1);
    tick();
    chk_b("t4_drain10", 1'b1, 4'd10, 2'b00);
    tick();
    chk_b("t4_drain11", 1'b1, 4'd11, 2'b00);
    tick();
    chk("t4_drained", 32'(b_valid), 32'd0);
    chk("t4_outst_0", 32'(outstanding), 32'd0);
    b_ready = 1'b0;
    // Leftover OKAY burst pairs with the next AW
    aw_valid = 1'b1; aw_id = 4'd2;
    tick();
    aw_valid = 1'b0;
    tick();
    chk_b("t4_leftover", 1'b1, 4'd2, 2'b00);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;

    // Reset mid-operation with a response pending and two pairs queued
    for (int i = 0; i < 3; i++) begin
      aw_valid = 1'b1; aw_id = 4'(4 + i); w_valid = 1'b1; w_last = 1'b1; w_err = 1'b0;
      tick();
    end
    aw_valid = 1'b0; w_valid = 1'b0; w_last = 1'b0;
    chk_b("t5_pre", 1'b1, 4'd4, 2'b00);
    chk("t5_pre_outst", 32'(outstanding), 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_b("t5_post", 1'b0, 4'd0, 2'b00);
    chk("t5_outst", 32'(outstanding), 32'd0);
    chk("t5_aw_ready", 32'(aw_ready), 32'd1);
    chk("t5_w_ready", 32'(w_ready), 32'd1);
    tick();
    chk("t5_no_stale", 32'(b_valid), 32'd0);
    aw_valid = 1'b1; aw_id = 4'd7; w_valid = 1'b1; w_last = 1'b1; w_err = 1'b1;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0; w_last = 1'b0; w_err = 1'b0;
    tick();
    chk_b("t5_fresh", 1'b1, 4'd7, 2'b10);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    chk("t5_end_valid", 32'(b_valid), 32'd0);
    chk("t5_end_outst", 32'(outstanding), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
